// File: rtl/fifo_pkg.sv
// Shared async-FIFO pointer helpers: Gray/binary conversion and the full compare.
// Used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH_DEF = 3;
  localparam int FIFO_AF_MARGIN_DEF  = 2;
  localparam int FIFO_PTR_MAX        = 32;

  // Helpers work on a wide container; callers zero-extend and truncate.
  typedef logic [FIFO_PTR_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[FIFO_PTR_MAX-1] = g[FIFO_PTR_MAX-1];
    for (int i = FIFO_PTR_MAX-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
  function automatic logic full_match(input ptr_t wgray, input ptr_t rgray, input int pw);
    ptr_t flip;
    flip = ptr_t'(3) << (pw - 2);
    return wgray == (rgray ^ flip);
  endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Write-side FIFO controller bus: producer request, synced read pointer in; address, flags, Gray pointer out.
// WR_OVF is present only when FIFO_WR_OVF_FLAG_EN is defined.
interface fifo_wr_ptr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
);
  localparam int PW = ADDR_WIDTH + 1;

  logic                  W_INC;
  logic [PW-1:0]         WQ2_RPTR;
  logic [ADDR_WIDTH-1:0] WADDR;
  logic                  W_EN;
  logic [PW-1:0]         WPTR;
  logic                  FULL;
  logic                  ALMOST_FULL;
  logic [PW-1:0]         WR_LEVEL;
`ifdef FIFO_WR_OVF_FLAG_EN
  logic                  WR_OVF;
`endif

  modport master (
    output W_INC, WQ2_RPTR,
    input  WADDR, W_EN, WPTR, FULL, ALMOST_FULL, WR_LEVEL
`ifdef FIFO_WR_OVF_FLAG_EN
    , input WR_OVF
`endif
  );

  modport slave (
    input  W_INC, WQ2_RPTR,
    output WADDR, W_EN, WPTR, FULL, ALMOST_FULL, WR_LEVEL
`ifdef FIFO_WR_OVF_FLAG_EN
    , output WR_OVF
`endif
  );

endinterface

// File: rtl/fifo_gray_cnt.sv
// Binary + Gray pointer counter with increment enable; registered outputs update one cycle after inc.
// No backpressure of its own: the caller gates inc.
module fifo_gray_cnt
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] bin,
  output logic [W-1:0] bin_next,
  output logic [W-1:0] gray,
  output logic [W-1:0] gray_next
);

  assign bin_next  = bin + W'(inc);
  assign gray_next = W'(bin2gray(ptr_t'(bin_next)));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_next;
      gray <= gray_next;
    end
  end

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Async-FIFO write pointer/flag generator; flags and pointer registered, W_EN combinational, writes while FULL dropped.
// Optional sticky overflow flag WR_OVF under FIFO_WR_OVF_FLAG_EN.
module fifo_wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF,
  parameter int AF_MARGIN  = FIFO_AF_MARGIN_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  fifo_wr_ptr_ctrl_if.slave bus
);

  localparam int            PW       = ADDR_WIDTH + 1;
  localparam int            DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wbin, wbin_next, wgray, wgray_next;
  logic [PW-1:0] rbin, level_next, level_q;
  logic          full_q, afull_q, w_acc;

  assign w_acc = bus.W_INC & ~full_q;

  fifo_gray_cnt #(.W(PW)) u_wcnt (
    .CLK       (CLK),
    .RST       (RST),
    .inc       (w_acc),
    .bin       (wbin),
    .bin_next  (wbin_next),
    .gray      (wgray),
    .gray_next (wgray_next)
  );

  // Synced read pointer lags, so this level can only over-report.
  assign rbin       = PW'(gray2bin(ptr_t'(bus.WQ2_RPTR)));
  assign level_next = wbin_next - rbin;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
    end else begin
      full_q  <= full_match(ptr_t'(wgray_next), ptr_t'(bus.WQ2_RPTR), PW);
      afull_q <= (level_next >= AF_LEVEL);
      level_q <= level_next;
    end
  end

`ifdef FIFO_WR_OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
    end else if (bus.W_INC && full_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.WR_OVF = ovf_q;
`endif

  assign bus.WADDR       = wbin[ADDR_WIDTH-1:0];
  assign bus.W_EN        = w_acc;
  assign bus.WPTR        = wgray;
  assign bus.FULL        = full_q;
  assign bus.ALMOST_FULL = afull_q;
  assign bus.WR_LEVEL    = level_q;

endmodule
